ioexp_input_tracker: RTL and testbench
======================================

// Module: ioexp_input_tracker
// PURPOSE
//  Conditions the active-low open-drain INT pin of a PCAL6416A and issues the
//  read request (irq) consumed by the I/O-expander controller.
//  Consumes the 16-bit pin words that controller reads back, keeps the
//  last-known pin state and accumulates sticky per-pin rise/fall events.
//  Also provides a periodic poll so lost interrupts cannot stall input state.
// PARAMETERS
//  SYNC_STAGES   2        flops in int_n synchronizer (>=2)
//  DEBOUNCE_CYC  256      cycles int_n must be stable low before it counts (>=1)
//  POLL_CYC      1048576  cycles between forced polls; 0 disables polling
//  TIMEOUT_CYC   65536    max cycles irq held without rd_done before abort (>=1)
//  HOLDOFF_CYC   64       min cycles from rd_done to next irq (>=1)
//  EVT_MASK      16'hFFFF pins allowed to generate rise/fall events
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  int_n     in   1   raw INT pin from expander, asynchronous, active low
//  irq       out  1   read request to controller; level, held until rd_done/timeout
//  rd_done   in   1   1-cycle pulse: read finished, rd_data valid this cycle
//  rd_data   in   16  pin word read from expander
//  pins      out  16  last accepted pin word
//  pins_vld  out  1   1 once the first read has been accepted
//  rise      out  16  sticky rising-edge flags (masked by EVT_MASK)
//  fall      out  16  sticky falling-edge flags (masked by EVT_MASK)
//  evt_clr   in   16  write-1-to-clear for rise and fall, 1-cycle pulses
//  evt       out  1   OR of rise|fall, registered
//  timeout   out  1   1-cycle pulse when a request is aborted by TIMEOUT_CYC
// BEHAVIOUR
//  Reset values: irq=1 (forces initial read), pins=0, pins_vld=0, rise=0,
//   fall=0, evt=0, timeout=0, sync chain=1 (deasserted), all counters=0,
//   state=PEND. Reset may assert mid-request; all state discarded, no event.
//  int_lvl: int_n synchronized, inverted; debounced = int_lvl stable 1 for
//   DEBOUNCE_CYC consecutive cycles; any 0 restarts the debounce counter.
//  Poll counter runs in IDLE only; reaches POLL_CYC-1 -> poll_req, counter clears.
//  FSM:
//   IDLE:    debounced | poll_req -> PEND (irq=1 next cycle, 1-cycle latency).
//   PEND:    irq=1. rd_done -> HOLD. timeout counter reaches TIMEOUT_CYC-1
//            -> timeout pulse, -> HOLD. rd_done same cycle as expiry: rd_done wins,
//            no timeout pulse.
//   HOLD:    irq=0 for HOLDOFF_CYC cycles, then -> IDLE. Debounce still tracks;
//            INT held low through HOLD re-requests on the IDLE cycle (level, not edge).
//  rd_done outside PEND: data still accepted (below), FSM unaffected.
//  Data accept on rd_done (same edge, 1-cycle latency to outputs):
//   first accept after reset: pins<=rd_data, pins_vld<=1, no events.
//   later: rise |= ~pins & rd_data & EVT_MASK; fall |= pins & ~rd_data & EVT_MASK;
//          pins<=rd_data.
//  evt_clr bit set and new event on same bit same cycle: set wins (bit stays 1).
//  evt = |(rise|fall), registered from next-state values (same cycle as flags).
//  Counter widths sized by $clog2 of their parameter; no wrap beyond terminal count.
// TESTING
//  Reset released, int_n=1 -> irq=1 next cycle; rd_done with 16'hA5A5 ->
//   pins=A5A5, pins_vld=1, rise=fall=0, irq=0 for 64 cycles then stays 0.
//  int_n low 255 cycles then high -> no irq; low 256+ cycles -> irq rises
//   SYNC_STAGES+256+1 cycles after fall (+-1).
//  pins=00FF, rd_done data 0F0F -> rise=0F00, fall=00F0, evt=1; evt_clr=0F00
//   -> rise=0, evt=1; evt_clr=00F0 -> evt=0.
//  evt_clr=0001 same cycle as rd_done creating rise[0] -> rise[0]=1.
//  irq high, no rd_done for TIMEOUT_CYC -> timeout 1-cycle pulse, irq=0,
//   HOLD, then re-request if int_n still low.
//  POLL_CYC=1000, int_n=1 -> irq every 1000+HOLDOFF+1 cycles; reset mid-PEND
//   -> outputs return to reset values, no event flags set.

Source files
------------

// File: rtl/ioexp_input_tracker.sv
// ---------------------------------------------------------------------------
// ioexp_input_tracker
//
// Conditions the active-low open-drain INT pin of a PCAL6416A I/O expander.
// It raises a read request (irq) for the expander controller and takes the
// 16-bit pin words that the controller reads back. It keeps the last-known
// pin state and gathers sticky per-pin rise/fall events. A periodic poll
// makes sure that a lost interrupt cannot leave the input state stale.
//
// Ports
//   clk       in   1   system clock
//   reset     in   1   asynchronous, active-high reset
//   int_n     in   1   raw INT pin (asynchronous, active low)
//   irq       out  1   read request; a level held until rd_done or timeout
//   rd_done   in   1   1-cycle pulse: read finished, rd_data valid
//   rd_data   in   16  pin word read from the expander
//   pins      out  16  last accepted pin word
//   pins_vld  out  1   set once the first read has been accepted
//   rise      out  16  sticky rising-edge flags (masked by EVT_MASK)
//   fall      out  16  sticky falling-edge flags (masked by EVT_MASK)
//   evt_clr   in   16  write-1-to-clear for rise and fall
//   evt       out  1   registered OR of all rise/fall flags
//   timeout   out  1   1-cycle pulse when a request is aborted
// ---------------------------------------------------------------------------
module ioexp_input_tracker #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 256,
    parameter int unsigned POLL_CYC     = 1048576,
    parameter int unsigned TIMEOUT_CYC  = 65536,
    parameter int unsigned HOLDOFF_CYC  = 64,
    parameter logic [15:0] EVT_MASK     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_n,
    output logic        irq,
    input  logic        rd_done,
    input  logic [15:0] rd_data,
    output logic [15:0] pins,
    output logic        pins_vld,
    output logic [15:0] rise,
    output logic [15:0] fall,
    input  logic [15:0] evt_clr,
    output logic        evt,
    output logic        timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Each counter is sized to reach its terminal count and no further.
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int HLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam int PH_W  = (TMO_W > HLD_W) ? TMO_W : HLD_W;

    localparam logic [DEB_W-1:0] DEB_TERM = DEB_W'(DEBOUNCE_CYC);
    localparam logic [PH_W-1:0]  TMO_LAST = PH_W'(TIMEOUT_CYC - 1);
    localparam logic [PH_W-1:0]  HLD_LAST = PH_W'(HOLDOFF_CYC - 1);

    // ------------------------------------------------------------------
    // INT synchronizer. It resets to 1 so that the pin reads as deasserted.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = int_n;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic int_lvl;
    assign int_lvl = ~sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: the counter saturates at DEBOUNCE_CYC. It keeps 'debounced'
    // high for as long as INT stays low, so a held interrupt re-requests
    // after each holdoff.
    // ------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             debounced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt_reg <= '0;
        end else if (!int_lvl) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg != DEB_TERM) begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
    end

    assign debounced = (deb_cnt_reg == DEB_TERM);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [PH_W-1:0] phase_cnt_reg;
    logic            timeout_next;
    logic            poll_req;
    logic            irq_reg;
    logic            timeout_reg;

    // Poll counter: it counts only while idle and restarts on each IDLE
    // entry. As a result, the poll period is measured from the end of the
    // previous holdoff.
    generate
        if (POLL_CYC == 0) begin : g_no_poll
            assign poll_req = 1'b0;
        end else begin : g_poll
            localparam int POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
            localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYC - 1);
            logic [POLL_W-1:0] poll_cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    poll_cnt_reg <= '0;
                end else if (state_reg != IDLE || poll_cnt_reg == POLL_LAST) begin
                    poll_cnt_reg <= '0;
                end else begin
                    poll_cnt_reg <= poll_cnt_reg + 1'b1;
                end
            end

            assign poll_req = (state_reg == IDLE) && (poll_cnt_reg == POLL_LAST);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (debounced || poll_req) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                // A completed read takes priority over an expiry in the same cycle.
                if (rd_done) begin
                    state_next = HOLD;
                end else if (phase_cnt_reg == TMO_LAST) begin
                    state_next   = HOLD;
                    timeout_next = 1'b1;
                end
            end
            HOLD: begin
                if (phase_cnt_reg == HLD_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = PEND;
        endcase
    end

    // A single phase counter serves both PEND (timeout) and HOLD (holdoff).
    // It restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= PEND;
            phase_cnt_reg <= '0;
            irq_reg       <= 1'b1;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            irq_reg     <= (state_next == PEND);
            timeout_reg <= timeout_next;
            if (state_next != state_reg || state_reg == IDLE) begin
                phase_cnt_reg <= '0;
            end else begin
                phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pin state and sticky events. The clear is applied first so that a
    // new event on the same bit wins.
    // ------------------------------------------------------------------
    logic [15:0] pins_reg;
    logic        pins_vld_reg;
    logic [15:0] rise_reg;
    logic [15:0] fall_reg;
    logic [15:0] rise_next;
    logic [15:0] fall_next;
    logic        evt_reg;

    always_comb begin
        rise_next = rise_reg & ~evt_clr;
        fall_next = fall_reg & ~evt_clr;
        if (rd_done && pins_vld_reg) begin
            rise_next = rise_next | (~pins_reg & rd_data & EVT_MASK);
            fall_next = fall_next | (pins_reg & ~rd_data & EVT_MASK);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pins_reg     <= '0;
            pins_vld_reg <= 1'b0;
            rise_reg     <= '0;
            fall_reg     <= '0;
            evt_reg      <= 1'b0;
        end else begin
            rise_reg <= rise_next;
            fall_reg <= fall_next;
            evt_reg  <= |(rise_next | fall_next);
            if (rd_done) begin
                pins_reg     <= rd_data;
                pins_vld_reg <= 1'b1;
            end
        end
    end

    assign irq      = irq_reg;
    assign timeout  = timeout_reg;
    assign pins     = pins_reg;
    assign pins_vld = pins_vld_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign evt      = evt_reg;

endmodule

// File: tb/tb_ioexp_input_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for ioexp_input_tracker. A reference model built from run
// lengths and timestamps predicts every output on every cycle. Directed
// scenarios cover the latency and boundary cases. A randomized phase
// follows them.
// ---------------------------------------------------------------------------
module tb_ioexp_input_tracker;

    localparam int          S    = 2;
    localparam int          DEB  = 256;
    localparam int          POLL = 1000;
    localparam int          TMO  = 400;
    localparam int          HOLD = 64;
    localparam logic [15:0] MASK = 16'h7FFF;

    logic        clk;
    logic        reset;
    logic        int_n;
    logic        irq;
    logic        rd_done;
    logic [15:0] rd_data;
    logic [15:0] pins;
    logic        pins_vld;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] evt_clr;
    logic        evt;
    logic        timeout;

    ioexp_input_tracker #(
        .SYNC_STAGES (S),
        .DEBOUNCE_CYC(DEB),
        .POLL_CYC    (POLL),
        .TIMEOUT_CYC (TMO),
        .HOLDOFF_CYC (HOLD),
        .EVT_MASK    (MASK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .int_n   (int_n),
        .irq     (irq),
        .rd_done (rd_done),
        .rd_data (rd_data),
        .pins    (pins),
        .pins_vld(pins_vld),
        .rise    (rise),
        .fall    (fall),
        .evt_clr (evt_clr),
        .evt     (evt),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model.
    //   lowq holds the "consecutive edges with int_n sampled low" value
    //   for the last S+1 edges. INT takes S edges to cross the
    //   synchronizer and one more edge to be counted, so lowq[0] is the
    //   stable-low run that the request logic sees now.
    //   m_mode: 0 idle, 1 request pending, 2 holdoff. m_enter is the edge
    //   index at which the current mode began.
    // ------------------------------------------------------------------
    int          m_mode;
    longint      m_cyc;
    longint      m_enter;
    int          lowq[$];
    int          lowrun;
    logic [15:0] m_pins;
    logic [15:0] m_rise;
    logic [15:0] m_fall;
    bit          m_vld;
    bit          m_evt;
    bit          m_tmo;

    task automatic model_reset();
        m_mode  = 1;
        m_cyc   = 0;
        m_enter = 0;
        lowq.delete();
        for (int i = 0; i <= S; i++) lowq.push_back(0);
        lowrun = 0;
        m_pins = '0;
        m_rise = '0;
        m_fall = '0;
        m_vld  = 0;
        m_evt  = 0;
        m_tmo  = 0;
    endtask

    always @(posedge clk or posedge reset) begin : model
        bit     deb;
        longint age;
        if (reset) begin
            model_reset();
        end else begin
            deb   = (lowq[0] >= DEB);
            age   = m_cyc - m_enter;
            m_tmo = 0;
            case (m_mode)
                0: if (deb || (POLL != 0 && age == POLL - 1)) begin
                    m_mode = 1; m_enter = m_cyc + 1;
                end
                1: if (rd_done) begin
                    m_mode = 2; m_enter = m_cyc + 1;
                end else if (age == TMO - 1) begin
                    m_mode = 2; m_enter = m_cyc + 1; m_tmo = 1;
                    $display("timeout at t=%0t", $time);
                end
                default: if (age == HOLD - 1) begin
                    m_mode = 0; m_enter = m_cyc + 1;
                end
            endcase
            lowrun = int_n ? 0 : lowrun + 1;
            lowq.push_back(lowrun);
            void'(lowq.pop_front());

            m_rise = m_rise & ~evt_clr;
            m_fall = m_fall & ~evt_clr;
            if (rd_done) begin
                if (m_vld) begin
                    m_rise = m_rise | (~m_pins & rd_data & MASK);
                    m_fall = m_fall | (m_pins & ~rd_data & MASK);
                end
                m_pins = rd_data;
                m_vld  = 1;
                $display("rd_done data=%04h -> pins=%04h rise=%04h fall=%04h", rd_data, m_pins, m_rise, m_fall);
            end
            m_evt = ((m_rise | m_fall) != 16'h0);
            m_cyc++;
        end
    end

    // Compare all outputs against the model shortly after every active edge.
    always @(posedge clk) begin
        #1;
        chk("irq",      32'(irq),      32'(m_mode == 1));
        chk("timeout",  32'(timeout),  32'(m_tmo));
        chk("pins",     32'(pins),     32'(m_pins));
        chk("pins_vld", 32'(pins_vld), 32'(m_vld));
        chk("rise",     32'(rise),     32'(m_rise));
        chk("fall",     32'(fall),     32'(m_fall));
        chk("evt",      32'(evt),      32'(m_evt));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Every step starts and ends on a falling edge.
    // ------------------------------------------------------------------
    task automatic pulse_rd(input logic [15:0] d, input logic [15:0] clr);
        rd_data = d;
        rd_done = 1'b1;
        evt_clr = clr;
        @(negedge clk);
        rd_done = 1'b0;
        evt_clr = '0;
    endtask

    task automatic clr_pulse(input logic [15:0] clr);
        evt_clr = clr;
        @(negedge clk);
        evt_clr = '0;
    endtask

    task automatic wait_irq(input logic lvl, input int bound, output int n);
        n = 0;
        while (irq !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("irq_wait", 32'(irq), 32'(lvl));
    endtask

    initial begin
        int n;
        int run_left;
        int resp;
        bit prev_irq;

        reset   = 1'b1;
        int_n   = 1'b1;
        rd_done = 1'b0;
        rd_data = '0;
        evt_clr = '0;
        repeat (3) @(negedge clk);
        chk("rst_irq",  32'(irq), 32'd1);
        chk("rst_pins", 32'(pins), 32'd0);
        chk("rst_flags", {rise, fall}, 32'd0);
        chk("rst_misc", 32'({pins_vld, evt, timeout}), 32'd0);

        // Initial forced read
        reset = 1'b0;
        @(negedge clk);
        chk("init_irq", 32'(irq), 32'd1);
        pulse_rd(16'hA5A5, 16'h0);
        chk("first_pins", 32'(pins), 32'h0000A5A5);
        chk("first_vld", 32'(pins_vld), 32'd1);
        chk("first_noevt", {rise, fall}, 32'd0);
        chk("first_irq_low", 32'(irq), 32'd0);
        repeat (74) @(negedge clk);
        chk("idle_irq_low", 32'(irq), 32'd0);

        // INT low for one cycle less than the debounce time: no request
        int_n = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        int_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("deb_short_irq", 32'(irq), 32'd0);

        // INT held low: check the latency from the falling edge to irq
        int_n = 1'b0;
        wait_irq(1'b1, 600, n);
        chk("deb_latency", 32'(n), 32'(S + DEB + 1));
        int_n = 1'b1;
        pulse_rd(16'h00FF, 16'h0);
        clr_pulse(16'hFFFF);
        repeat (5) @(negedge clk);
        pulse_rd(16'h0F0F, 16'h0);
        chk("evt_rise", 32'(rise), 32'h00000F00);
        chk("evt_fall", 32'(fall), 32'h000000F0);
        chk("evt_or", 32'(evt), 32'd1);
        clr_pulse(16'h0F00);
        chk("clr_rise", 32'(rise), 32'd0);
        chk("clr_evt_still", 32'(evt), 32'd1);
        clr_pulse(16'h00F0);
        chk("clr_evt_gone", 32'(evt), 32'd0);

        // A set takes priority over a clear on the same bit
        pulse_rd(16'h0F0E, 16'h0);
        chk("fall0", 32'(fall[0]), 32'd1);
        clr_pulse(16'hFFFF);
        pulse_rd(16'h0F0F, 16'h0001);
        chk("clr_vs_set", 32'(rise[0]), 32'd1);

        // Timeout, followed by a re-request while INT is still held low
        repeat (80) @(negedge clk);
        int_n = 1'b0;
        wait_irq(1'b1, 600, n);
        n = 0;
        while (irq && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_len", 32'(n), 32'(TMO));
        chk("tmo_pulse", 32'(timeout), 32'd1);
        wait_irq(1'b1, 200, n);
        chk("rereq_gap", 32'(n), 32'(HOLD + 1));
        int_n = 1'b1;
        pulse_rd(16'h3C3C, 16'h0);

        // Periodic poll with INT idle
        wait_irq(1'b1, 1200, n);
        for (int k = 0; k < 2; k++) begin
            pulse_rd(16'($urandom), 16'h0);
            wait_irq(1'b1, 1200, n);
            chk("poll_period", 32'(n + 1), 32'(POLL + HOLD + 1));
        end

        // Reset while a request is pending
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_irq", 32'(irq), 32'd1);
        chk("midrst_pins", 32'(pins), 32'd0);
        chk("midrst_flags", {rise, fall}, 32'd0);
        chk("midrst_misc", 32'({pins_vld, evt, timeout}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_rd(16'h1234, 16'h0);
        chk("postrst_pins", 32'(pins), 32'h00001234);
        chk("postrst_noevt", {rise, fall}, 32'd0);

        // Randomized traffic, checked cycle by cycle against the model
        run_left = 0;
        resp     = -1;
        prev_irq = 1'b0;
        for (int c = 0; c < 25000; c++) begin
            if (run_left == 0) begin
                int_n    = ~int_n;
                run_left = int_n ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 400));
            end
            run_left--;
            rd_done = 1'b0;
            evt_clr = '0;
            if (irq && !prev_irq) resp = int'($urandom_range(0, TMO + 50));
            if (irq && resp == 0) begin
                rd_done = 1'b1;
                rd_data = 16'($urandom);
                resp    = -1;
            end else if (resp > 0) begin
                resp--;
            end
            if (!rd_done && $urandom_range(0, 499) == 0) begin
                rd_done = 1'b1;
                rd_data = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) evt_clr = 16'($urandom);
            reset    = ($urandom_range(0, 3999) == 0);
            prev_irq = irq;
            @(negedge clk);
        end
        reset   = 1'b0;
        rd_done = 1'b0;
        evt_clr = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
